// File: rtl/pipeline_stall_ctrl.sv
// Central hazard controller for the 5-stage pipeline: zero-latency stall/flush
// generation plus mul/div occupancy, memory wait tracking and stall statistics.
module pipeline_stall_ctrl #(
   parameter int unsigned MULDIV_CYCLES = 32,
   parameter int unsigned MEM_TIMEOUT   = 255
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [4:0]  ID_Rs,
   input  logic [4:0]  ID_Rt,
   input  logic        ID_UsesRs,
   input  logic        ID_UsesRt,
   input  logic        ID_MulDivUse,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_Rd,
   input  logic        EX_BranchTaken,
   input  logic        EX_MulDivStart,
   input  logic        MEM_Req,
   input  logic        MEM_Ready,
   output logic        PC_stall,
   output logic        IF_ID_stall,
   output logic        IF_ID_flush,
   output logic        ID_EX_stall,
   output logic        ID_EX_flush,
   output logic        EX_MEM_stall,
   output logic        EX_MEM_flush,
   output logic        MEM_WB_stall,
   output logic        MEM_WB_flush,
   output logic        MulDiv_busy,
   output logic        Mem_Timeout,
   output logic [15:0] Stall_Count
);

   localparam int unsigned MD_W   = 8;
   localparam int unsigned WAIT_W = 16;
   localparam int unsigned CNT_W  = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_t;

   mem_state_t        r_state;
   logic [MD_W-1:0]   r_md_cnt;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic              r_timeout;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic              w_mem_wait;
   logic              w_load_use;
   logic              w_md_hazard;
   logic [WAIT_W-1:0] w_wait_inc;

   assign w_mem_wait  = MEM_Req & ~MEM_Ready;
   assign w_load_use  = EX_MemRead & (EX_Rd != 5'd0) &
                        ((ID_UsesRs & (ID_Rs == EX_Rd)) | (ID_UsesRt & (ID_Rt == EX_Rd)));
   assign w_md_hazard = ID_MulDivUse & MulDiv_busy;
   assign w_wait_inc  = (r_wait_cnt == {WAIT_W{1'b1}}) ? r_wait_cnt : r_wait_cnt + WAIT_W'(1);

   assign MulDiv_busy = (r_md_cnt != MD_W'(0));
   assign Mem_Timeout = r_timeout;
   assign Stall_Count = r_stall_cnt;

   // Prioritised stall/flush decode; segments flush-before-stall so reset only flushes
   always_comb begin
      PC_stall     = 1'b0;
      IF_ID_stall  = 1'b0;
      IF_ID_flush  = 1'b0;
      ID_EX_stall  = 1'b0;
      ID_EX_flush  = 1'b0;
      EX_MEM_stall = 1'b0;
      EX_MEM_flush = 1'b0;
      MEM_WB_stall = 1'b0;
      MEM_WB_flush = 1'b0;
      if (!Rst_n) begin
         IF_ID_flush  = 1'b1;
         ID_EX_flush  = 1'b1;
         EX_MEM_flush = 1'b1;
         MEM_WB_flush = 1'b1;
      end else if (w_mem_wait) begin
         // a taken branch stays parked in EX until memory releases
         PC_stall     = 1'b1;
         IF_ID_stall  = 1'b1;
         ID_EX_stall  = 1'b1;
         EX_MEM_stall = 1'b1;
         MEM_WB_flush = 1'b1;
      end else if (EX_BranchTaken) begin
         IF_ID_flush  = 1'b1;
         ID_EX_flush  = 1'b1;
      end else if (w_load_use || w_md_hazard) begin
         PC_stall     = 1'b1;
         IF_ID_stall  = 1'b1;
         ID_EX_flush  = 1'b1;
      end
   end

   // Mul/div occupancy countdown; a start held by a memory stall does not launch
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_md_cnt <= '0;
      end else if (EX_MulDivStart && !w_mem_wait) begin
         r_md_cnt <= MD_W'(MULDIV_CYCLES - 1);
      end else if (r_md_cnt != MD_W'(0)) begin
         r_md_cnt <= r_md_cnt - MD_W'(1);
      end
   end

   // Memory wait FSM with saturating wait counter and sticky timeout
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state    <= ST_IDLE;
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_mem_wait) begin
                  r_state    <= ST_WAIT;
                  r_wait_cnt <= w_wait_inc;
               end else begin
                  r_wait_cnt <= '0;
               end
            end
            ST_WAIT: begin
               if (w_mem_wait) begin
                  r_wait_cnt <= w_wait_inc;
               end else begin
                  r_state    <= ST_IDLE;
                  r_wait_cnt <= '0;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_wait_cnt <= '0;
            end
         endcase
         if (w_mem_wait && (w_wait_inc == WAIT_W'(MEM_TIMEOUT))) begin
            r_timeout <= 1'b1;
         end
      end
   end

   // Saturating count of PC stall cycles
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_stall_cnt <= '0;
      end else if (PC_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: per-cycle expected outputs are queued
// when inputs are driven and compared against the DUT mid-cycle.
module tb_pipeline_stall_ctrl;

   logic        clk;
   logic        rst_n;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rs;
   logic        id_uses_rt;
   logic        id_muldiv_use;
   logic        ex_mem_read;
   logic [4:0]  ex_rd;
   logic        ex_branch_taken;
   logic        ex_muldiv_start;
   logic        mem_req;
   logic        mem_ready;

   logic        pc_stall;
   logic        if_id_stall;
   logic        if_id_flush;
   logic        id_ex_stall;
   logic        id_ex_flush;
   logic        ex_mem_stall;
   logic        ex_mem_flush;
   logic        mem_wb_stall;
   logic        mem_wb_flush;
   logic        muldiv_busy;
   logic        mem_timeout;
   logic [15:0] stall_count;

   typedef struct packed {
      logic        pc_s;
      logic        ifid_s;
      logic        ifid_f;
      logic        idex_s;
      logic        idex_f;
      logic        exmem_s;
      logic        exmem_f;
      logic        memwb_s;
      logic        memwb_f;
      logic        busy;
      logic        tmo;
      logic [15:0] cnt;
   } exp_t;

   exp_t q_exp[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   pipeline_stall_ctrl #(
      .MULDIV_CYCLES (4),
      .MEM_TIMEOUT   (5)
   ) u_dut (
      .Clk            (clk),
      .Rst_n          (rst_n),
      .ID_Rs          (id_rs),
      .ID_Rt          (id_rt),
      .ID_UsesRs      (id_uses_rs),
      .ID_UsesRt      (id_uses_rt),
      .ID_MulDivUse   (id_muldiv_use),
      .EX_MemRead     (ex_mem_read),
      .EX_Rd          (ex_rd),
      .EX_BranchTaken (ex_branch_taken),
      .EX_MulDivStart (ex_muldiv_start),
      .MEM_Req        (mem_req),
      .MEM_Ready      (mem_ready),
      .PC_stall       (pc_stall),
      .IF_ID_stall    (if_id_stall),
      .IF_ID_flush    (if_id_flush),
      .ID_EX_stall    (id_ex_stall),
      .ID_EX_flush    (id_ex_flush),
      .EX_MEM_stall   (ex_mem_stall),
      .EX_MEM_flush   (ex_mem_flush),
      .MEM_WB_stall   (mem_wb_stall),
      .MEM_WB_flush   (mem_wb_flush),
      .MulDiv_busy    (muldiv_busy),
      .Mem_Timeout    (mem_timeout),
      .Stall_Count    (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
      id_muldiv_use = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
      ex_branch_taken = 1'b0; ex_muldiv_start = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   // Status fields and the flush/stall vector (reset-view vs run-view)
   function automatic exp_t mk(input logic [8:0] ctl, input logic busy, input logic tmo,
                               input logic [15:0] cnt);
      exp_t e;
      {e.pc_s, e.ifid_s, e.ifid_f, e.idex_s, e.idex_f,
       e.exmem_s, e.exmem_f, e.memwb_s, e.memwb_f} = ctl;
      e.busy = busy;
      e.tmo  = tmo;
      e.cnt  = cnt;
      return e;
   endfunction

   // ctl order: pc_s ifid_s ifid_f idex_s idex_f exmem_s exmem_f memwb_s memwb_f
   localparam logic [8:0] C_NONE   = 9'b000000000;
   localparam logic [8:0] C_RESET  = 9'b001010101;
   localparam logic [8:0] C_MEMW   = 9'b110101000 | 9'b000000001;
   localparam logic [8:0] C_BRANCH = 9'b001010000;
   localparam logic [8:0] C_HAZ    = 9'b110010000;

   // Inputs are already set at a negedge; push the expectation, then sample mid-cycle
   task automatic cycle(input exp_t e);
      exp_t got;
      q_exp.push_back(e);
      #2;
      if (q_exp.size() == 0) begin
         check("queue_empty", 16'd1, 16'd0);
      end else begin
         got = q_exp.pop_front();
         check("PC_stall",     16'(pc_stall),     16'(got.pc_s));
         check("IF_ID_stall",  16'(if_id_stall),  16'(got.ifid_s));
         check("IF_ID_flush",  16'(if_id_flush),  16'(got.ifid_f));
         check("ID_EX_stall",  16'(id_ex_stall),  16'(got.idex_s));
         check("ID_EX_flush",  16'(id_ex_flush),  16'(got.idex_f));
         check("EX_MEM_stall", 16'(ex_mem_stall), 16'(got.exmem_s));
         check("EX_MEM_flush", 16'(ex_mem_flush), 16'(got.exmem_f));
         check("MEM_WB_stall", 16'(mem_wb_stall), 16'(got.memwb_s));
         check("MEM_WB_flush", 16'(mem_wb_flush), 16'(got.memwb_f));
         check("MulDiv_busy",  16'(muldiv_busy),  16'(got.busy));
         check("Mem_Timeout",  16'(mem_timeout),  16'(got.tmo));
         check("Stall_Count",  stall_count,       got.cnt);
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      @(negedge clk);

      // Reset held for two cycles
      cycle(mk(C_RESET, 1'b0, 1'b0, 16'd0));
      cycle(mk(C_RESET, 1'b0, 1'b0, 16'd0));
      rst_n = 1'b1;
      cycle(mk(C_NONE, 1'b0, 1'b0, 16'd0));

      // Load-use on rt, then on rs, then non-hazards
      ex_mem_read = 1'b1; ex_rd = 5'd8; id_rt = 5'd8; id_uses_rt = 1'b1;
      cycle(mk(C_HAZ, 1'b0, 1'b0, 16'd0));
      idle_inputs();
      cycle(mk(C_NONE, 1'b0, 1'b0, 16'd1));
      ex_mem_read = 1'b1; ex_rd = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
      cycle(mk(C_NONE, 1'b0, 1'b0, 16'd1));
      idle_inputs();
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
      cycle(mk(C_HAZ, 1'b0, 1'b0, 16'd1));
      id_uses_rs = 1'b0;
      cycle(mk(C_NONE, 1'b0, 1'b0, 16'd2));
      idle_inputs();

      // Memory wait with a pending taken branch, then release
      mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) cycle(mk(C_MEMW, 1'b0, 1'b0, 16'(2 + i)));
      mem_ready = 1'b1;
      cycle(mk(C_BRANCH, 1'b0, 1'b0, 16'd5));
      idle_inputs();
      cycle(mk(C_NONE, 1'b0, 1'b0, 16'd5));

      // Mul/div occupancy of 4 cycles, hazard from t+2 until busy drops
      ex_muldiv_start = 1'b1;
      cycle(mk(C_NONE, 1'b0, 1'b0, 16'd5));
      idle_inputs();
      cycle(mk(C_NONE, 1'b1, 1'b0, 16'd5));
      id_muldiv_use = 1'b1;
      cycle(mk(C_HAZ, 1'b1, 1'b0, 16'd5));
      cycle(mk(C_HAZ, 1'b1, 1'b0, 16'd6));
      cycle(mk(C_NONE, 1'b0, 1'b0, 16'd7));
      idle_inputs();

      // Start while memory stalls does not launch the unit
      ex_muldiv_start = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
      cycle(mk(C_MEMW, 1'b0, 1'b0, 16'd7));
      idle_inputs();
      cycle(mk(C_NONE, 1'b0, 1'b0, 16'd8));

      // Branch wins over a simultaneous load-use
      ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3; id_rt = 5'd3; id_uses_rt = 1'b1;
      cycle(mk(C_BRANCH, 1'b0, 1'b0, 16'd8));
      idle_inputs();

      // Five consecutive wait cycles trip the sticky timeout
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) cycle(mk(C_MEMW, 1'b0, 1'b0, 16'(8 + i)));
      mem_ready = 1'b1;
      cycle(mk(C_NONE, 1'b0, 1'b1, 16'd13));
      idle_inputs();
      cycle(mk(C_NONE, 1'b0, 1'b1, 16'd13));

      // Reset mid mul/div clears everything asynchronously
      ex_muldiv_start = 1'b1;
      cycle(mk(C_NONE, 1'b0, 1'b1, 16'd13));
      idle_inputs();
      cycle(mk(C_NONE, 1'b1, 1'b1, 16'd13));
      rst_n = 1'b0;
      cycle(mk(C_RESET, 1'b0, 1'b0, 16'd0));
      rst_n = 1'b1;
      cycle(mk(C_NONE, 1'b0, 1'b0, 16'd0));
      id_muldiv_use = 1'b1;
      cycle(mk(C_NONE, 1'b0, 1'b0, 16'd0));
      idle_inputs();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
